// File: rtl/spice_node_acc.sv
// spice_node_acc
// N-input circuit-node integrator for the SPICE-style netlist engine.
// Each step sums the N branch currents into a registered adder stage. The
// sum is then scaled by 1/C, modelled as an arithmetic right shift by CSHIFT.
// The scaled value is integrated into the node voltage with saturation.
// A hold input pins the node to an external voltage (driven node / rail), and
// a sticky flag records any integration that had to be clipped.
//
// Parameters:
//   W       signed width of each branch current and of the node voltage
//   N       number of branch-current inputs
//   CSHIFT  arithmetic right shift applied to the summed current
//
// Ports:
//   eclk     in   engine clock, all state updates on the rising edge
//   ereset   in   asynchronous active-high reset
//   i_in     in   N*W flattened signed currents, input k at [k*W +: W]
//   step     in   integrate strobe, samples i_in on this edge
//   hold     in   force v to vhold on this edge
//   vhold    in   W-bit signed hold voltage
//   clr_sat  in   clear the sticky saturation flag
//   v        out  W-bit signed node voltage
//   vld      out  one-cycle pulse, v was updated by integration
//   sat      out  sticky flag, an integration clipped
module spice_node_acc #(
    parameter int W      = 16,
    parameter int N      = 4,
    parameter int CSHIFT = 0
) (
    input  logic                eclk,
    input  logic                ereset,
    input  logic [N*W-1:0]      i_in,
    input  logic                step,
    input  logic                hold,
    input  logic signed [W-1:0] vhold,
    input  logic                clr_sat,
    output logic signed [W-1:0] v,
    output logic                vld,
    output logic                sat
);

    // Sum width grows by ceil(log2 N) bits so the adder tree can never wrap.
    localparam int SW = (N == 1) ? W : W + $clog2(N);

    localparam logic signed [W-1:0]  VMAXW = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0]  VMINW = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [SW:0]   TMAX  = (SW+1)'(VMAXW);
    localparam logic signed [SW:0]   TMIN  = (SW+1)'(VMINW);

    logic signed [SW-1:0] sumAll;
    logic signed [SW-1:0] isum;
    logic                 p1;
    logic signed [SW-1:0] dScaled;
    logic signed [SW:0]   tSum;
    logic signed [W-1:0]  vInt;
    logic                 clip;

    // Adder stage: sign-extend every branch current to SW bits and add them.
    always_comb begin
        sumAll = '0;
        for (int k = 0; k < N; k++) begin
            sumAll = sumAll + SW'($signed(i_in[k*W +: W]));
        end
    end

    // Integration stage: scale by 1/C (floor shift), add to v one bit wider
    // than the sum so the addition itself cannot overflow, then clamp to the
    // representable voltage range and flag whether clamping occurred.
    always_comb begin
        dScaled = isum >>> CSHIFT;
        tSum    = (SW+1)'(v) + (SW+1)'(dScaled);
        vInt    = tSum[W-1:0];
        clip    = 1'b0;
        if (tSum > TMAX) begin
            vInt = VMAXW;
            clip = 1'b1;
        end else if (tSum < TMIN) begin
            vInt = VMINW;
            clip = 1'b1;
        end
    end

    // State update. hold overrides a pending integration on the same edge,
    // yet stage 1 keeps capturing so integration resumes from vhold. A clip
    // on the same edge as clr_sat leaves the flag set.
    always_ff @(posedge eclk or posedge ereset) begin
        if (ereset) begin
            isum <= '0;
            p1   <= 1'b0;
            v    <= '0;
            vld  <= 1'b0;
            sat  <= 1'b0;
        end else begin
            if (step) begin
                isum <= sumAll;
                p1   <= 1'b1;
            end else begin
                p1   <= 1'b0;
            end

            if (hold) begin
                v   <= vhold;
                vld <= 1'b0;
            end else if (p1) begin
                v   <= vInt;
                vld <= 1'b1;
            end else begin
                vld <= 1'b0;
            end

            if (p1 && !hold && clip) begin
                sat <= 1'b1;
            end else if (clr_sat) begin
                sat <= 1'b0;
            end
        end
    end

endmodule
